inc_dec_unit: RTL and testbench
===============================

Name: inc_dec_unit

Overview:
Parametrised, registered increment/decrement unit for the UrCPU ALU arithmetic group. It succeeds the fixed 20-bit combinational decrementer. It adds:
- selectable INC/DEC and step-add/step-sub operations
- wrap or saturate overflow handling
- carry/borrow/zero/saturate flags
- a one-entry output register with valid/ready backpressure

It sits between the ALU operand mux and the writeback/flag logic.

Parameters:
- WIDTH, 20, data path width in bits (>=2)
- STEP_W, 8, width of the step operand (1..WIDTH)
- SATURATE, 0, reset value of the mode bit: 0 = wrap, 1 = saturate

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand/op valid
- in_ready  out  1  unit can accept this cycle
- data_input  in  WIDTH  operand A
- step  in  STEP_W  step operand, zero-extended to WIDTH; used by ADDK/SUBK only
- op  in  2  operation code (see package)
- sat_mode  in  1  per-operation overflow mode: 1 = saturate, 0 = wrap
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- flag_zero  out  1  result == 0
- flag_carry  out  1  unsigned overflow on INC/ADDK
- flag_borrow  out  1  unsigned underflow on DEC/SUBK
- flag_sat  out  1  result was clamped

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, result=0
  - all flags=0
  - in_ready=1 on the following cycle
  - an accepted-but-unconsumed result is discarded
  - in_valid is ignored while rst=1
- Handshake:
  - in_ready = !out_valid || out_ready (combinational pass-through of out_ready, single-entry pipe).
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
- Latency is exactly 1 cycle. An operand accepted at edge N appears with out_valid=1 after edge N.
- Full throughput: with out_ready held at 1, back-to-back inputs yield back-to-back results.
- Backpressure: while out_valid && !out_ready, result and flags hold stable and in_ready=0.
- Simultaneous pop and push in one cycle: the new result replaces the old one and out_valid stays 1.
- Pop without push: out_valid goes 0 and result/flags hold their last value (don't-care).
- Arithmetic is computed at WIDTH+1 bits, unsigned. Let k be the operand (1 for INC/DEC, zero-extended step for ADDK/SUBK).
- OP_INC / OP_ADDK: sum = A + k.
  - flag_carry = sum[WIDTH].
  - Wrap: result = sum[WIDTH-1:0].
  - Saturate: if carry, result = all-ones and flag_sat=1.
- OP_DEC / OP_SUBK: diff = A - k.
  - flag_borrow = (A < k).
  - Wrap: result = diff[WIDTH-1:0].
  - Saturate: if borrow, result = 0 and flag_sat=1.
- ADDK/SUBK with step=0: result=A and all flags 0 except zero.
- Carry is 0 on DEC ops; borrow is 0 on INC ops.
- flag_zero is evaluated on the final (post-clamp) result.
- sat_mode is sampled with the operand. The SATURATE parameter is the default value the integration layer ties to sat_mode.

Decomposition:
- Package inc_dec_pkg holds:
  - op localparams: OP_INC=2'd0, OP_DEC=2'd1, OP_ADDK=2'd2, OP_SUBK=2'd3
  - flag bit index constants for packing into the status word
- One natural sub-module, inc_dec_core: purely combinational (A, k, op, sat_mode) -> (result, flags).
- inc_dec_unit adds the handshake and output register around the core.

Test Plan (WIDTH=20, STEP_W=8):
- DEC, A=0x10000, wrap, out_ready=1 -> one cycle later result=0x0FFFF, all flags 0, out_valid=1 for exactly 1 cycle.
- DEC, A=0x00000: wrap -> 0xFFFFF, borrow=1, sat=0. Saturate -> 0x00000, borrow=1, sat=1, zero=1.
- INC, A=0xFFFFF: wrap -> 0x00000, carry=1, zero=1. ADDK with step=0x10 and A=0xFFFF8 in saturate -> 0xFFFFF, carry=1, sat=1.
- Backpressure: push 0x00005 (SUBK step=5) with out_ready=0 for 3 cycles.
  - result=0, zero=1, held stable.
  - in_ready=0 and a second in_valid is not taken.
  - Raise out_ready: the held result pops and the second operand is accepted the same cycle.
- Streaming: 8 consecutive INC operands 0..7 with out_ready=1 -> results 1..8 on 8 consecutive cycles, no bubbles.
- Reset mid-operation: a result pending with out_ready=0, then assert rst for 1 cycle -> out_valid=0, result=0, flags=0, in_ready=1 next cycle; the pending result is never delivered.

Source files
------------

// File: rtl/inc_dec_pkg.sv
// Shared opcodes and status-word flag positions for the increment/decrement unit.
package inc_dec_pkg;

    localparam logic [1:0] OP_INC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_ADDK = 2'd2;
    localparam logic [1:0] OP_SUBK = 2'd3;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_CARRY  = 1;
    localparam int FLAG_BORROW = 2;
    localparam int FLAG_SAT    = 3;
    localparam int NUM_FLAGS   = 4;

    function automatic logic op_is_add(input logic [1:0] op);
        return (op == OP_INC) || (op == OP_ADDK);
    endfunction

endpackage

// File: rtl/inc_dec_core.sv
// Combinational add/subtract-by-k datapath with wrap or saturate overflow handling.
module inc_dec_core
    import inc_dec_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int STEP_W = 8
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [STEP_W-1:0]    step,
    input  logic [1:0]           op,
    input  logic                 sat_mode,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags
);

    logic [WIDTH:0] k_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        k_ext = '0;
        case (op)
            OP_INC, OP_DEC: k_ext = {{WIDTH{1'b0}}, 1'b1};
            default:        k_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
        endcase
    end

    // One extra bit: for add it is the carry, for subtract it goes high exactly when a < k.
    assign sum  = {1'b0, a} + k_ext;
    assign diff = {1'b0, a} - k_ext;

    always_comb begin
        result = '0;
        flags  = '0;
        if (op_is_add(op)) begin
            flags[FLAG_CARRY] = sum[WIDTH];
            if (sum[WIDTH] && sat_mode) begin
                result          = '1;
                flags[FLAG_SAT] = 1'b1;
            end else begin
                result = sum[WIDTH-1:0];
            end
        end else begin
            flags[FLAG_BORROW] = diff[WIDTH];
            if (diff[WIDTH] && sat_mode) begin
                result          = '0;
                flags[FLAG_SAT] = 1'b1;
            end else begin
                result = diff[WIDTH-1:0];
            end
        end
        flags[FLAG_ZERO] = (result == '0);
    end

endmodule

// File: rtl/inc_dec_unit.sv
// Registered increment/decrement unit: single-entry output register with valid/ready
// handshake wrapped around the combinational core.
module inc_dec_unit
    import inc_dec_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int STEP_W   = 8,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  data_input,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        op,
    input  logic              sat_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_borrow,
    output logic              flag_sat
);

    if (WIDTH < 2 || STEP_W < 1 || STEP_W > WIDTH || SATURATE < 0 || SATURATE > 1)
    begin : g_param_check
        $error("inc_dec_unit: illegal WIDTH/STEP_W/SATURATE combination");
    end

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [WIDTH-1:0]     core_result;
    logic [NUM_FLAGS-1:0] core_flags;
    logic                 accept;

    inc_dec_core #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_core (
        .a        (data_input),
        .step     (step),
        .op       (op),
        .sat_mode (sat_mode),
        .result   (core_result),
        .flags    (core_flags)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A push always wins, so a same-cycle pop and push keeps out_valid high with the new result.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = core_result;
            flags_d     = core_flags;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign flag_zero   = flags_q[FLAG_ZERO];
    assign flag_carry  = flags_q[FLAG_CARRY];
    assign flag_borrow = flags_q[FLAG_BORROW];
    assign flag_sat    = flags_q[FLAG_SAT];

endmodule

// File: tb/tb_inc_dec_unit.sv
// Directed-vector bench for inc_dec_unit (WIDTH=20, STEP_W=8) with hand-computed expectations.
module tb_inc_dec_unit;

    localparam int WIDTH  = 20;
    localparam int STEP_W = 8;

    localparam logic [1:0] T_INC  = 2'd0;
    localparam logic [1:0] T_DEC  = 2'd1;
    localparam logic [1:0] T_ADDK = 2'd2;
    localparam logic [1:0] T_SUBK = 2'd3;

    // Flag nibble order used in every expectation: {zero, carry, borrow, sat}.
    localparam logic [3:0] F_NONE = 4'b0000;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  data_input;
    logic [STEP_W-1:0] step;
    logic [1:0]        op;
    logic              sat_mode;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              flag_zero;
    logic              flag_carry;
    logic              flag_borrow;
    logic              flag_sat;

    int testCount = 0;
    int failCount = 0;

    inc_dec_unit #(
        .WIDTH    (WIDTH),
        .STEP_W   (STEP_W),
        .SATURATE (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_input  (data_input),
        .step        (step),
        .op          (op),
        .sat_mode    (sat_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry),
        .flag_borrow (flag_borrow),
        .flag_sat    (flag_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] flagNibble();
        return {flag_zero, flag_carry, flag_borrow, flag_sat};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs are checked in the same window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [WIDTH-1:0] a,
                                 input logic [STEP_W-1:0] s, input logic sm, input logic ordy);
        in_valid   = v;
        op         = o;
        data_input = a;
        step       = s;
        sat_mode   = sm;
        out_ready  = ordy;
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [STEP_W-1:0] s, input logic sm,
                         input logic [WIDTH-1:0] expResult, input logic [3:0] expFlags);
        applyStimulus(1'b1, o, a, s, sm, 1'b1);
        tick();
        in_valid = 1'b0;
        checkOutput({tag, ".valid"},  32'(out_valid), 32'd1);
        checkOutput({tag, ".result"}, 32'(result), 32'(expResult));
        checkOutput({tag, ".flags"},  32'(flagNibble()), 32'(expFlags));
        tick();
        checkOutput({tag, ".drain"},  32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, T_INC, 20'h00123, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        in_valid = 1'b0;
        rst      = 1'b0;
        checkOutput("reset.valid",  32'(out_valid), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.flags",  32'(flagNibble()), 32'(F_NONE));
        checkOutput("reset.ready",  32'(in_ready), 32'd1);

        runOp("dec_plain",   T_DEC,  20'h10000, 8'h00, 1'b0, 20'h0FFFF, F_NONE);
        runOp("dec0_wrap",   T_DEC,  20'h00000, 8'h00, 1'b0, 20'hFFFFF, 4'b0010);
        runOp("dec0_sat",    T_DEC,  20'h00000, 8'h00, 1'b1, 20'h00000, 4'b1011);
        runOp("incmax_wrap", T_INC,  20'hFFFFF, 8'h00, 1'b0, 20'h00000, 4'b1100);
        runOp("incmax_sat",  T_INC,  20'hFFFFF, 8'h00, 1'b1, 20'hFFFFF, 4'b0101);
        runOp("addk_sat",    T_ADDK, 20'hFFFF8, 8'h10, 1'b1, 20'hFFFFF, 4'b0101);
        runOp("addk_wrap",   T_ADDK, 20'hFFFF8, 8'h10, 1'b0, 20'h00008, 4'b0100);
        runOp("addk_step0",  T_ADDK, 20'h12345, 8'h00, 1'b1, 20'h12345, F_NONE);
        runOp("subk_step0",  T_SUBK, 20'h00000, 8'h00, 1'b1, 20'h00000, 4'b1000);
        runOp("subk_wrap",   T_SUBK, 20'h00003, 8'h05, 1'b0, 20'hFFFFE, 4'b0010);
        runOp("subk_fullk",  T_SUBK, 20'h00100, 8'hFF, 1'b0, 20'h00001, F_NONE);

        // Backpressure: first result sits in the register while a second operand waits.
        applyStimulus(1'b1, T_SUBK, 20'h00005, 8'h05, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, T_INC, 20'h00100, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp.ready%0d", i),  32'(in_ready), 32'd0);
            checkOutput($sformatf("bp.valid%0d", i),  32'(out_valid), 32'd1);
            checkOutput($sformatf("bp.result%0d", i), 32'(result), 32'd0);
            checkOutput($sformatf("bp.flags%0d", i),  32'(flagNibble()), 32'(4'b1000));
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp.release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp.second_valid",  32'(out_valid), 32'd1);
        checkOutput("bp.second_result", 32'(result), 32'h00101);
        checkOutput("bp.second_flags",  32'(flagNibble()), 32'(F_NONE));
        tick();
        checkOutput("bp.drain", 32'(out_valid), 32'd0);

        // Streaming with out_ready held high: one result per cycle, no bubbles.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, T_INC, WIDTH'(i), 8'h00, 1'b0, 1'b1);
            tick();
            checkOutput($sformatf("stream.valid%0d", i),  32'(out_valid), 32'd1);
            checkOutput($sformatf("stream.result%0d", i), 32'(result), 32'(i + 1));
        end
        in_valid = 1'b0;
        tick();
        checkOutput("stream.drain", 32'(out_valid), 32'd0);

        // Reset while a result is pending: it must be discarded, never delivered.
        applyStimulus(1'b1, T_INC, 20'h0AAAA, 8'h00, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("midrst.pending_valid",  32'(out_valid), 32'd1);
        checkOutput("midrst.pending_result", 32'(result), 32'h0AAAB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst.valid",  32'(out_valid), 32'd0);
        checkOutput("midrst.result", 32'(result), 32'd0);
        checkOutput("midrst.flags",  32'(flagNibble()), 32'(F_NONE));
        checkOutput("midrst.ready",  32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst.never%0d", i), 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
